// File: rtl/dac_stream_router.sv
// dac_stream_router: runtime crossbar from DSP channels onto RFDC DAC
// AXI4-stream lanes, with zero-fill remap, beat counters and sticky flags.
module dac_stream_router #(
    parameter int NIN       = 9,
    parameter int NOUT      = 16,
    parameter int DATAWIDTH = 256,
    parameter int SELWIDTH  = $clog2(NIN + 1),
    parameter int ZEROBEATS = 4,
    parameter int CNTWIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic [NOUT*SELWIDTH-1:0]  map,
    input  logic                      stb_map,
    input  logic                      stb_clr,
    input  logic [NIN*DATAWIDTH-1:0]  din,
    input  logic [NIN-1:0]            din_valid,
    output logic [NOUT*DATAWIDTH-1:0] tdata,
    output logic [NOUT-1:0]           tvalid,
    input  logic [NOUT-1:0]           tready,
    output logic [NOUT*CNTWIDTH-1:0]  cnt,
    output logic [NOUT-1:0]           underrun,
    output logic [NOUT-1:0]           overrun,
    output logic                      remap_busy
);
    localparam logic [SELWIDTH-1:0] MUTED = SELWIDTH'(NIN);
    localparam logic [7:0]          ZLOAD = 8'(ZEROBEATS);

    typedef enum logic {RUN, MUTE} state_t;

    state_t              state  [NOUT];
    logic [SELWIDTH-1:0] sel    [NOUT];
    logic [SELWIDTH-1:0] shadow [NOUT];
    logic [7:0]          zleft  [NOUT];
    logic [NOUT-1:0]     started;
    logic                pend;
    logic                rst_q;

    logic [DATAWIDTH-1:0] src_data [NOUT];
    logic [NOUT-1:0] src_valid;
    logic [NOUT-1:0] acc;
    logic [NOUT-1:0] live;
    logic [NOUT-1:0] in_mute;
    logic [NOUT-1:0] ev_ovr;
    logic [NOUT-1:0] ev_und;
    logic [NOUT-1:0] remap;
    logic [NOUT-1:0] run_load;
    logic [NOUT-1:0] run_valid;

    function automatic logic [SELWIDTH-1:0] clamp(input logic [SELWIDTH-1:0] f);
        return (f > MUTED) ? MUTED : f;
    endfunction

    assign acc        = tvalid & tready;
    assign remap_busy = |in_mute;

    always_comb begin
        for (int k = 0; k < NOUT; k++) begin
            src_valid[k] = 1'b0;
            src_data[k]  = '0;
            for (int i = 0; i < NIN; i++) begin
                if (sel[k] == SELWIDTH'(i)) begin
                    src_valid[k] = din_valid[i];
                    src_data[k]  = din[i*DATAWIDTH +: DATAWIDTH];
                end
            end
            in_mute[k]   = (state[k] == MUTE);
            live[k]      = !in_mute[k] && (sel[k] != MUTED);
            ev_ovr[k]    = live[k] & src_valid[k] & tvalid[k] & ~tready[k];
            ev_und[k]    = live[k] & tready[k] & ~tvalid[k] & started[k];
            remap[k]     = pend & ((shadow[k] != sel[k]) | in_mute[k]);
            run_valid[k] = (sel[k] == MUTED) | src_valid[k];
            // A muted lane streams zeros; a live one refills only when the slot frees
            run_load[k]  = (sel[k] == MUTED) |
                           (src_valid[k] ? (~tvalid[k] | tready[k]) : tready[k]);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) rst_q <= 1'b0;
        else          rst_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pend     <= 1'b0;
            started  <= '0;
            tdata    <= '0;
            tvalid   <= '0;
            cnt      <= '0;
            underrun <= '0;
            overrun  <= '0;
            for (int k = 0; k < NOUT; k++) begin
                state[k]  <= RUN;
                sel[k]    <= MUTED;
                shadow[k] <= MUTED;
                zleft[k]  <= '0;
            end
        end else if (rst_q) begin
            pend <= stb_map;
            for (int k = 0; k < NOUT; k++) begin
                if (stb_map)
                    shadow[k] <= clamp(map[k*SELWIDTH +: SELWIDTH]);
                cnt[k*CNTWIDTH +: CNTWIDTH] <= stb_clr ? CNTWIDTH'(acc[k]) :
                    cnt[k*CNTWIDTH +: CNTWIDTH] + CNTWIDTH'(acc[k]);
                underrun[k] <= (underrun[k] & ~stb_clr) | ev_und[k];
                overrun[k]  <= (overrun[k] & ~stb_clr) | ev_ovr[k];
                if (remap[k]) begin
                    state[k]   <= MUTE;
                    sel[k]     <= shadow[k];
                    zleft[k]   <= ZLOAD;
                    started[k] <= 1'b0;
                    tvalid[k]  <= 1'b1;
                    tdata[k*DATAWIDTH +: DATAWIDTH] <= '0;
                end else if (in_mute[k]) begin
                    if (acc[k]) begin
                        zleft[k] <= zleft[k] - 8'd1;
                        if (zleft[k] == 8'd1) begin
                            state[k]   <= RUN;
                            started[k] <= 1'b0;
                            if (run_load[k]) begin
                                tdata[k*DATAWIDTH +: DATAWIDTH] <= src_data[k];
                                tvalid[k] <= run_valid[k];
                            end
                        end
                    end
                end else begin
                    if (acc[k])
                        started[k] <= 1'b1;
                    if (run_load[k]) begin
                        tdata[k*DATAWIDTH +: DATAWIDTH] <= src_data[k];
                        tvalid[k] <= run_valid[k];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dac_stream_router.sv
// tb_dac_stream_router: directed and randomized checks of the lane crossbar
// against a behavioural model of the lane rules.
module tb_dac_stream_router;
    localparam int NIN  = 9;
    localparam int NOUT = 16;
    localparam int DW   = 32;
    localparam int SW   = 4;
    localparam int ZB   = 4;
    localparam int CW   = 8;

    logic                 clk = 1'b0;
    logic                 aresetn;
    logic [NOUT*SW-1:0]   map;
    logic                 stb_map;
    logic                 stb_clr;
    logic [NIN*DW-1:0]    din;
    logic [NIN-1:0]       din_valid;
    logic [NOUT*DW-1:0]   tdata;
    logic [NOUT-1:0]      tvalid;
    logic [NOUT-1:0]      tready;
    logic [NOUT*CW-1:0]   cnt;
    logic [NOUT-1:0]      underrun;
    logic [NOUT-1:0]      overrun;
    logic                 remap_busy;

    int errors = 0;
    int checks = 0;
    int ramp   = 1;

    int          m_sel[NOUT];
    int          m_shadow[NOUT];
    int          m_zleft[NOUT];
    int          m_cnt[NOUT];
    bit          m_mute[NOUT];
    bit          m_valid[NOUT];
    bit          m_ur[NOUT];
    bit          m_ov[NOUT];
    bit          m_started[NOUT];
    logic [DW-1:0] m_data[NOUT];
    bit          m_pend;
    bit          m_live;

    always #5 clk = ~clk;

    dac_stream_router #(
        .NIN(NIN), .NOUT(NOUT), .DATAWIDTH(DW), .SELWIDTH(SW),
        .ZEROBEATS(ZB), .CNTWIDTH(CW)
    ) dut (
        .clk(clk), .aresetn(aresetn), .map(map), .stb_map(stb_map),
        .stb_clr(stb_clr), .din(din), .din_valid(din_valid),
        .tdata(tdata), .tvalid(tvalid), .tready(tready), .cnt(cnt),
        .underrun(underrun), .overrun(overrun), .remap_busy(remap_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_field(input int k, input int v);
        map[k*SW +: SW] = SW'(v);
    endtask

    task automatic drive_ramp();
        for (int i = 0; i < NIN; i++)
            din[i*DW +: DW] = (i << 24) | ramp;
        ramp++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NOUT; k++) begin
            m_sel[k] = NIN; m_shadow[k] = NIN; m_zleft[k] = 0; m_cnt[k] = 0;
            m_mute[k] = 0; m_valid[k] = 0; m_ur[k] = 0; m_ov[k] = 0;
            m_started[k] = 0; m_data[k] = '0;
        end
        m_pend = 0;
        m_live = 0;
    endtask

    // One clock edge of the lane rules, using the inputs currently driven
    task automatic model_edge();
        bit acc, sv, eo, eu, run_now;
        int s, f;
        logic [DW-1:0] sd;
        if (!aresetn) return;
        if (!m_live) begin
            m_live = 1;
            return;
        end
        for (int k = 0; k < NOUT; k++) begin
            acc = m_valid[k] && tready[k];
            s = m_sel[k];
            sv = 0;
            sd = '0;
            if (s < NIN) begin
                sv = din_valid[s];
                sd = din[s*DW +: DW];
            end
            eo = !m_mute[k] && s < NIN && sv && m_valid[k] && !tready[k];
            eu = !m_mute[k] && s < NIN && tready[k] && !m_valid[k] && m_started[k];
            m_cnt[k] = stb_clr ? int'(acc) : (m_cnt[k] + int'(acc)) % (1 << CW);
            m_ur[k] = (m_ur[k] && !stb_clr) || eu;
            m_ov[k] = (m_ov[k] && !stb_clr) || eo;
            if (m_pend && (m_shadow[k] != s || m_mute[k])) begin
                m_mute[k] = 1; m_sel[k] = m_shadow[k]; m_zleft[k] = ZB;
                m_data[k] = '0; m_valid[k] = 1; m_started[k] = 0;
            end else begin
                run_now = !m_mute[k];
                if (m_mute[k] && acc) begin
                    m_zleft[k]--;
                    if (m_zleft[k] == 0) begin
                        m_mute[k] = 0; m_started[k] = 0; run_now = 1;
                    end
                end else if (!m_mute[k] && acc) begin
                    m_started[k] = 1;
                end
                if (run_now) begin
                    if (s == NIN) begin
                        m_data[k] = '0; m_valid[k] = 1;
                    end else if (sv) begin
                        if (!m_valid[k] || tready[k]) begin
                            m_data[k] = sd; m_valid[k] = 1;
                        end
                    end else if (tready[k]) begin
                        m_valid[k] = 0;
                    end
                end
            end
        end
        if (stb_map)
            for (int k = 0; k < NOUT; k++) begin
                f = int'(map[k*SW +: SW]);
                m_shadow[k] = (f > NIN) ? NIN : f;
            end
        m_pend = stb_map;
    endtask

    task automatic compare_all();
        logic [NOUT-1:0] ev, eu, eo;
        bit busy;
        busy = 0;
        for (int k = 0; k < NOUT; k++) begin
            ev[k] = m_valid[k]; eu[k] = m_ur[k]; eo[k] = m_ov[k];
            busy |= m_mute[k];
        end
        check("tvalid", tvalid, ev);
        check("underrun", underrun, eu);
        check("overrun", overrun, eo);
        check("remap_busy", remap_busy, busy);
        for (int k = 0; k < NOUT; k++) begin
            if (m_valid[k])
                check($sformatf("tdata%0d", k), tdata[k*DW +: DW], m_data[k]);
            check($sformatf("cnt%0d", k), cnt[k*CW +: CW], m_cnt[k]);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    int  zeros;
    bit  seen;
    logic [DW-1:0] exp_hold;
    int  exp_cnt;

    initial begin
        aresetn = 0; stb_map = 0; stb_clr = 0;
        din = '0; din_valid = '0; tready = '1;
        for (int k = 0; k < NOUT; k++) set_field(k, NIN);
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        check("rst_tdata0", tdata[0 +: DW], 0);
        check("rst_tdata15", tdata[15*DW +: DW], 0);

        aresetn = 1;
        repeat (12) tick();
        check("t1_cnt0", cnt[0 +: CW], 10);
        check("t1_cnt15", cnt[15*CW +: CW], 10);

        din_valid = '1;
        drive_ramp();
        set_field(0, 2); set_field(3, 0); stb_map = 1;
        tick();
        stb_map = 0; drive_ramp();
        tick();
        check("t2_busy", remap_busy, 1);
        zeros = 0; seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (!seen) begin
                if (tdata[0 +: DW] == 0) zeros++;
                else seen = 1;
            end
            drive_ramp();
            tick();
        end
        check("t2_zero_beats", zeros, ZB);
        check("t2_busy_end", remap_busy, 0);

        tready[0] = 0;
        exp_hold = m_data[0];
        exp_cnt = m_cnt[0];
        repeat (3) begin drive_ramp(); tick(); end
        check("t3_overrun", overrun[0], 1);
        check("t3_hold", tdata[0 +: DW], exp_hold);
        check("t3_cnt", cnt[0 +: CW], exp_cnt);
        tready[0] = 1;

        repeat (3) begin drive_ramp(); tick(); end
        din_valid[2] = 0;
        repeat (2) begin drive_ramp(); tick(); end
        check("t4_underrun", underrun[0], 1);
        stb_clr = 1;
        tick();
        check("t4_clr_event", underrun[0], 1);
        tready = '0; din_valid = '0;
        tick();
        stb_clr = 0;
        check("t4_ur_clr", underrun, 0);
        check("t4_ov_clr", overrun, 0);
        check("t4_cnt_clr", cnt[0 +: CW], 0);
        tready = '1; din_valid = '1;

        for (int i = 0; i < NIN; i++) din[i*DW +: DW] = 32'hA000_0000 + i;
        set_field(5, 1); stb_map = 1;
        tick();
        stb_map = 0;
        tick();
        set_field(5, 4); stb_map = 1;
        tick();
        stb_map = 0;
        tick();
        zeros = 0; seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (!seen) begin
                if (tdata[5*DW +: DW] == 0) zeros++;
                else seen = 1;
            end
            tick();
        end
        check("t5_zero_beats", zeros, ZB);
        check("t5_src", tdata[5*DW +: DW], 32'hA000_0004);
        check("t5_valid", tvalid[5], 1);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NIN; i++) din[i*DW +: DW] = $urandom;
            din_valid = NIN'($urandom);
            for (int k = 0; k < NOUT; k++) tready[k] = ($urandom_range(0, 3) != 0);
            stb_map = ($urandom_range(0, 19) == 0);
            if (stb_map)
                for (int k = 0; k < NOUT; k++) set_field(k, $urandom_range(0, 15));
            stb_clr = ($urandom_range(0, 24) == 0);
            tick();
        end
        stb_map = 0; stb_clr = 0;

        tready = '1; din_valid = '1;
        for (int k = 0; k < NOUT; k++) set_field(k, NIN);
        stb_map = 1;
        tick();
        stb_map = 0;
        repeat (12) tick();
        stb_clr = 1; tready = '0;
        tick();
        stb_clr = 0; tready = '1;
        repeat (257) tick();
        check("t6_wrap0", cnt[0 +: CW], 1);
        check("t6_wrap15", cnt[15*CW +: CW], 1);

        set_field(0, 3); stb_map = 1;
        tick();
        stb_map = 0;
        tick();
        check("t6_busy", remap_busy, 1);
        #2 aresetn = 0;
        #1;
        check("t6_rst_tvalid", tvalid, 0);
        check("t6_rst_cnt", cnt[0 +: CW], 0);
        check("t6_rst_busy", remap_busy, 0);
        model_reset();
        @(negedge clk);
        compare_all();
        tick();
        aresetn = 1;
        repeat (4) tick();
        check("t6_mute_valid", tvalid[0], 1);
        check("t6_mute_data", tdata[0 +: DW], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
